// File: rtl/chorus_cfg_sequencer_if.sv
// rtl/chorus_cfg_sequencer_if.sv - cfg, sample-stream and chorus program/enable bundle
// master = the sequencer, slave = the register bank / stream source / chorus side.
interface chorus_cfg_sequencer_if #(
  parameter int G_DWIDTH     = 24,
  parameter int G_ADDR_WIDTH = 12,
  parameter int G_DDS_WIDTH  = 32
);
  logic [G_DWIDTH-1:0]     cfg_gain0;
  logic [G_DWIDTH-1:0]     cfg_gain1;
  logic [G_ADDR_WIDTH-1:0] cfg_avg_delay;
  logic [G_ADDR_WIDTH-1:0] cfg_lfo_depth;
  logic [G_DDS_WIDTH-1:0]  cfg_lfo_freq;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic                    cfg_error;
  logic                    busy;

  logic [G_DWIDTH-1:0]     s_din;
  logic                    s_din_valid;
  logic                    s_din_ready;
  logic [G_DWIDTH-1:0]     ch_din;
  logic                    ch_din_valid;
  logic                    ch_din_ready;
  logic                    ch_dout_valid;
  logic                    ch_dout_ready;

  logic                    ch_enable;
  logic [G_DWIDTH-1:0]     ch_prog_gain_din;
  logic                    ch_prog_gain_valid;
  logic                    ch_prog_gain_ready;
  logic                    ch_prog_gain_done;
  logic [G_ADDR_WIDTH-1:0] ch_prog_avg_delay_din;
  logic                    ch_prog_avg_delay_valid;
  logic                    ch_prog_avg_delay_ready;
  logic                    ch_prog_avg_delay_done;
  logic [G_ADDR_WIDTH-1:0] ch_prog_lfo_depth_din;
  logic                    ch_prog_lfo_depth_valid;
  logic                    ch_prog_lfo_depth_ready;
  logic                    ch_prog_lfo_depth_done;
  logic [G_DDS_WIDTH-1:0]  ch_prog_lfo_freq_din;
  logic                    ch_prog_lfo_freq_valid;
  logic                    ch_prog_lfo_freq_ready;
  logic                    ch_prog_lfo_freq_done;

  modport master (
    input  cfg_gain0, cfg_gain1, cfg_avg_delay, cfg_lfo_depth, cfg_lfo_freq, cfg_valid,
    output cfg_ready, cfg_error, busy,
    input  s_din, s_din_valid,
    output s_din_ready,
    output ch_din, ch_din_valid,
    input  ch_din_ready, ch_dout_valid, ch_dout_ready,
    output ch_enable,
    output ch_prog_gain_din, ch_prog_gain_valid,
    input  ch_prog_gain_ready, ch_prog_gain_done,
    output ch_prog_avg_delay_din, ch_prog_avg_delay_valid,
    input  ch_prog_avg_delay_ready, ch_prog_avg_delay_done,
    output ch_prog_lfo_depth_din, ch_prog_lfo_depth_valid,
    input  ch_prog_lfo_depth_ready, ch_prog_lfo_depth_done,
    output ch_prog_lfo_freq_din, ch_prog_lfo_freq_valid,
    input  ch_prog_lfo_freq_ready, ch_prog_lfo_freq_done
  );

  modport slave (
    output cfg_gain0, cfg_gain1, cfg_avg_delay, cfg_lfo_depth, cfg_lfo_freq, cfg_valid,
    input  cfg_ready, cfg_error, busy,
    output s_din, s_din_valid,
    input  s_din_ready,
    input  ch_din, ch_din_valid,
    output ch_din_ready, ch_dout_valid, ch_dout_ready,
    input  ch_enable,
    input  ch_prog_gain_din, ch_prog_gain_valid,
    output ch_prog_gain_ready, ch_prog_gain_done,
    input  ch_prog_avg_delay_din, ch_prog_avg_delay_valid,
    output ch_prog_avg_delay_ready, ch_prog_avg_delay_done,
    input  ch_prog_lfo_depth_din, ch_prog_lfo_depth_valid,
    output ch_prog_lfo_depth_ready, ch_prog_lfo_depth_done,
    input  ch_prog_lfo_freq_din, ch_prog_lfo_freq_valid,
    output ch_prog_lfo_freq_ready, ch_prog_lfo_freq_done
  );
endinterface

// File: rtl/chorus_cfg_sequencer.sv
// rtl/chorus_cfg_sequencer.sv - quiesce / enable-pulse / reprogram / resume sequencer for one chorus
// Reconfiguration happens only between samples: the stream gate is open solely in S_RUN.
module chorus_cfg_sequencer #(
  parameter int G_DWIDTH        = 24,
  parameter int G_ADDR_WIDTH    = 12,
  parameter int G_DDS_WIDTH     = 32,
  parameter int G_DEF_GAIN0     = 2**22,
  parameter int G_DEF_GAIN1     = 0,
  parameter int G_DEF_AVG_DELAY = 1024,
  parameter int G_DEF_LFO_DEPTH = 256,
  parameter int G_DEF_LFO_FREQ  = 0,
  parameter int G_EN_LOW_CYCLES = 4,
  parameter int G_TIMEOUT       = 16384
) (
  input logic                   clk,
  input logic                   reset,
  chorus_cfg_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(G_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_EN_LOW,
    S_PROG,
    S_WAIT_RDY,
    S_RUN,
    S_DRAIN,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0]        r_cnt;
  logic [G_DWIDTH-1:0]     r_gain0;
  logic [G_DWIDTH-1:0]     r_gain1;
  logic [G_ADDR_WIDTH-1:0] r_avg_delay;
  logic [G_ADDR_WIDTH-1:0] r_lfo_depth;
  logic [G_DDS_WIDTH-1:0]  r_lfo_freq;
  logic                    r_enable;
  logic                    r_gain_valid;
  logic                    r_gain_beat;
  logic                    r_delay_valid;
  logic                    r_depth_valid;
  logic                    r_freq_valid;
  logic                    r_cfg_error;
  logic [1:0]              r_outstanding;

  logic w_pass;
  logic w_cfg_ready;
  logic w_cfg_fire;
  logic w_cfg_ok;
  logic w_all_done;
  logic w_timeout;
  logic w_en_low_done;
  logic w_din_fire;
  logic w_dout_fire;
  logic w_load;
  logic w_err;
  logic w_prog_entry;

  assign w_pass        = (r_state == S_RUN);
  assign w_cfg_ready   = (r_state == S_RUN) || (r_state == S_ERROR);
  assign w_cfg_fire    = bus.cfg_valid & w_cfg_ready;
  assign w_cfg_ok      = (bus.cfg_lfo_depth <= bus.cfg_avg_delay) && (bus.cfg_avg_delay != '0);
  assign w_all_done    = bus.ch_prog_gain_done & bus.ch_prog_avg_delay_done &
                         bus.ch_prog_lfo_depth_done & bus.ch_prog_lfo_freq_done;
  assign w_timeout     = (r_cnt == CNT_W'(G_TIMEOUT - 1));
  assign w_en_low_done = (r_cnt == CNT_W'(G_EN_LOW_CYCLES - 1));
  assign w_din_fire    = bus.s_din_valid & w_pass & bus.ch_din_ready;
  assign w_dout_fire   = bus.ch_dout_valid & bus.ch_dout_ready;
  assign w_prog_entry  = (w_next_state == S_PROG) && (r_state != S_PROG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_EN_LOW;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Timeout has priority over a simultaneous completion so a stuck visit always ends in S_ERROR.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_EN_LOW: begin
        if (w_en_low_done) begin
          w_next_state = S_PROG;
        end
      end
      S_PROG: begin
        if (w_timeout) begin
          w_err        = 1'b1;
          w_next_state = S_ERROR;
        end else if (w_all_done) begin
          w_next_state = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (w_timeout) begin
          w_err        = 1'b1;
          w_next_state = S_ERROR;
        end else if (bus.ch_din_ready) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_cfg_fire) begin
          if (w_cfg_ok) begin
            w_load       = 1'b1;
            w_next_state = S_DRAIN;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_timeout) begin
          w_err        = 1'b1;
          w_next_state = S_ERROR;
        end else if (r_outstanding == 2'd0) begin
          w_next_state = S_EN_LOW;
        end
      end
      S_ERROR: begin
        if (w_cfg_fire) begin
          if (w_cfg_ok) begin
            w_load       = 1'b1;
            w_next_state = S_EN_LOW;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = S_EN_LOW;
      end
    endcase
  end

  // Per-visit counter: cleared on every state change, saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gain0     <= G_DWIDTH'(G_DEF_GAIN0);
      r_gain1     <= G_DWIDTH'(G_DEF_GAIN1);
      r_avg_delay <= G_ADDR_WIDTH'(G_DEF_AVG_DELAY);
      r_lfo_depth <= G_ADDR_WIDTH'(G_DEF_LFO_DEPTH);
      r_lfo_freq  <= G_DDS_WIDTH'(G_DEF_LFO_FREQ);
    end else if (w_load) begin
      r_gain0     <= bus.cfg_gain0;
      r_gain1     <= bus.cfg_gain1;
      r_avg_delay <= bus.cfg_avg_delay;
      r_lfo_depth <= bus.cfg_lfo_depth;
      r_lfo_freq  <= bus.cfg_lfo_freq;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enable    <= 1'b0;
      r_cfg_error <= 1'b0;
    end else begin
      r_enable    <= (w_next_state == S_PROG) || (w_next_state == S_WAIT_RDY) ||
                     (w_next_state == S_RUN)  || (w_next_state == S_DRAIN);
      r_cfg_error <= w_err;
    end
  end

  // All four channels start together; gain steps to its second beat after the first transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gain_valid  <= 1'b0;
      r_gain_beat   <= 1'b0;
      r_delay_valid <= 1'b0;
      r_depth_valid <= 1'b0;
      r_freq_valid  <= 1'b0;
    end else if (w_prog_entry) begin
      r_gain_valid  <= 1'b1;
      r_gain_beat   <= 1'b0;
      r_delay_valid <= 1'b1;
      r_depth_valid <= 1'b1;
      r_freq_valid  <= 1'b1;
    end else if (w_next_state == S_PROG) begin
      if (r_gain_valid && bus.ch_prog_gain_ready) begin
        if (r_gain_beat) begin
          r_gain_valid <= 1'b0;
        end else begin
          r_gain_beat <= 1'b1;
        end
      end
      if (r_delay_valid && bus.ch_prog_avg_delay_ready) begin
        r_delay_valid <= 1'b0;
      end
      if (r_depth_valid && bus.ch_prog_lfo_depth_ready) begin
        r_depth_valid <= 1'b0;
      end
      if (r_freq_valid && bus.ch_prog_lfo_freq_ready) begin
        r_freq_valid <= 1'b0;
      end
    end else begin
      r_gain_valid  <= 1'b0;
      r_gain_beat   <= 1'b0;
      r_delay_valid <= 1'b0;
      r_depth_valid <= 1'b0;
      r_freq_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstanding <= 2'd0;
    end else begin
      case ({w_din_fire, w_dout_fire})
        2'b10:   r_outstanding <= r_outstanding + 2'd1;
        2'b01:   r_outstanding <= r_outstanding - 2'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign bus.cfg_ready    = w_cfg_ready;
  assign bus.cfg_error    = r_cfg_error;
  assign bus.busy         = (r_state != S_RUN);
  assign bus.s_din_ready  = bus.ch_din_ready & w_pass;
  assign bus.ch_din       = bus.s_din;
  assign bus.ch_din_valid = bus.s_din_valid & w_pass;
  assign bus.ch_enable    = r_enable;

  assign bus.ch_prog_gain_din        = r_gain_beat ? r_gain1 : r_gain0;
  assign bus.ch_prog_gain_valid      = r_gain_valid;
  assign bus.ch_prog_avg_delay_din   = r_avg_delay;
  assign bus.ch_prog_avg_delay_valid = r_delay_valid;
  assign bus.ch_prog_lfo_depth_din   = r_lfo_depth;
  assign bus.ch_prog_lfo_depth_valid = r_depth_valid;
  assign bus.ch_prog_lfo_freq_din    = r_lfo_freq;
  assign bus.ch_prog_lfo_freq_valid  = r_freq_valid;

endmodule

// File: tb/tb_chorus_cfg_sequencer.sv
// tb/tb_chorus_cfg_sequencer.sv - directed bench for chorus_cfg_sequencer with a small chorus model
module tb_chorus_cfg_sequencer;
  localparam int DW  = 24;
  localparam int AW  = 12;
  localparam int FW  = 32;
  localparam int TMO = 16384;
  localparam int CLR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chorus_cfg_sequencer_if #(.G_DWIDTH(DW), .G_ADDR_WIDTH(AW), .G_DDS_WIDTH(FW)) bus ();

  chorus_cfg_sequencer #(.G_DWIDTH(DW), .G_ADDR_WIDTH(AW), .G_DDS_WIDTH(FW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic          freq_rdy_en;
  logic [DW-1:0] cap_g0, cap_g1;
  logic [AW-1:0] cap_d, cap_dep;
  logic [FW-1:0] cap_f;
  int            gain_beats, clr_cnt;
  logic          done_g, done_d, done_dep, done_f;

  assign bus.ch_prog_gain_ready      = 1'b1;
  assign bus.ch_prog_avg_delay_ready = 1'b1;
  assign bus.ch_prog_lfo_depth_ready = 1'b1;
  assign bus.ch_prog_lfo_freq_ready  = freq_rdy_en;
  assign bus.ch_prog_gain_done       = done_g;
  assign bus.ch_prog_avg_delay_done  = done_d;
  assign bus.ch_prog_lfo_depth_done  = done_dep;
  assign bus.ch_prog_lfo_freq_done   = done_f;
  assign bus.ch_din_ready            = bus.ch_enable && (clr_cnt == CLR);

  // Chorus model: self-clears while disabled, captures program beats, clears its buffer for CLR cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !bus.ch_enable) begin
      cap_g0 <= '1; cap_g1 <= '1; cap_d <= '1; cap_dep <= '1; cap_f <= '1;
      gain_beats <= 0; clr_cnt <= 0;
      done_g <= 1'b0; done_d <= 1'b0; done_dep <= 1'b0; done_f <= 1'b0;
    end else begin
      if (clr_cnt < CLR) clr_cnt <= clr_cnt + 1;
      if (bus.ch_prog_gain_valid && bus.ch_prog_gain_ready) begin
        if (gain_beats == 0) cap_g0 <= bus.ch_prog_gain_din;
        if (gain_beats == 1) begin cap_g1 <= bus.ch_prog_gain_din; done_g <= 1'b1; end
        gain_beats <= gain_beats + 1;
      end
      if (bus.ch_prog_avg_delay_valid && bus.ch_prog_avg_delay_ready) begin
        cap_d <= bus.ch_prog_avg_delay_din; done_d <= 1'b1;
      end
      if (bus.ch_prog_lfo_depth_valid && bus.ch_prog_lfo_depth_ready) begin
        cap_dep <= bus.ch_prog_lfo_depth_din; done_dep <= 1'b1;
      end
      if (bus.ch_prog_lfo_freq_valid && bus.ch_prog_lfo_freq_ready) begin
        cap_f <= bus.ch_prog_lfo_freq_din; done_f <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cfg(input logic [DW-1:0] g0, input logic [DW-1:0] g1,
                          input logic [AW-1:0] d, input logic [AW-1:0] dep, input logic [FW-1:0] f);
    bus.cfg_gain0 = g0; bus.cfg_gain1 = g1; bus.cfg_avg_delay = d;
    bus.cfg_lfo_depth = dep; bus.cfg_lfo_freq = f; bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic count_en_low(input string tag);
    int n = 0;
    while (!bus.ch_enable && n < 100) begin n++; @(negedge clk); end
    check(tag, 64'(n), 64'd4);
  endtask

  task automatic wait_enable(input string tag, input logic lvl);
    int n = 0;
    while (bus.ch_enable !== lvl && n < 100) begin n++; @(negedge clk); end
    check(tag, 64'(bus.ch_enable), 64'(lvl));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    logic prev_rdy = 1'b0;
    while (bus.busy && n < 200) begin prev_rdy = bus.ch_din_ready; n++; @(negedge clk); end
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_rdy_before_run"}, 64'(prev_rdy), 64'd1);
  endtask

  task automatic check_prog(input string tag, input logic [DW-1:0] g0, input logic [DW-1:0] g1,
                            input logic [AW-1:0] d, input logic [AW-1:0] dep, input logic [FW-1:0] f);
    check({tag, "_gain0"}, 64'(cap_g0), 64'(g0));
    check({tag, "_gain1"}, 64'(cap_g1), 64'(g1));
    check({tag, "_beats"}, 64'(gain_beats), 64'd2);
    check({tag, "_delay"}, 64'(cap_d), 64'(d));
    check({tag, "_depth"}, 64'(cap_dep), 64'(dep));
    check({tag, "_freq"}, 64'(cap_f), 64'(f));
  endtask

  initial begin
    int n;
    freq_rdy_en = 1'b1;
    bus.cfg_gain0 = '0; bus.cfg_gain1 = '0; bus.cfg_avg_delay = '0;
    bus.cfg_lfo_depth = '0; bus.cfg_lfo_freq = '0; bus.cfg_valid = 1'b0;
    bus.s_din = 24'h00F00D; bus.s_din_valid = 1'b1;
    bus.ch_dout_valid = 1'b0; bus.ch_dout_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_enable", 64'(bus.ch_enable), 64'd0);
    check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    check("rst_cfg_error", 64'(bus.cfg_error), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd1);
    check("rst_s_din_ready", 64'(bus.s_din_ready), 64'd0);
    check("rst_ch_din_valid", 64'(bus.ch_din_valid), 64'd0);
    check("rst_valids", 64'({bus.ch_prog_gain_valid, bus.ch_prog_avg_delay_valid,
                              bus.ch_prog_lfo_depth_valid, bus.ch_prog_lfo_freq_valid}), 64'd0);

    // Default programming after release
    bus.s_din_valid = 1'b0;
    rst_n = 1'b1;
    count_en_low("boot_en_low");
    wait_idle("boot");
    check_prog("boot", 24'h400000, 24'h0, 12'd1024, 12'd256, 32'h0);
    check("boot_cfg_ready", 64'(bus.cfg_ready), 64'd1);

    // Pass-through and rejected cfg without disturbing the stream
    bus.s_din = 24'h0ABCDE; bus.s_din_valid = 1'b1; bus.ch_dout_valid = 1'b1;
    #1;
    check("pass_ch_din", 64'(bus.ch_din), 64'h0ABCDE);
    check("pass_ch_din_valid", 64'(bus.ch_din_valid), 64'd1);
    check("pass_s_din_ready", 64'(bus.s_din_ready), 64'd1);
    send_cfg(24'h111111, 24'h222222, 12'd200, 12'd300, 32'h5);
    check("rej_depth_error", 64'(bus.cfg_error), 64'd1);
    check("rej_depth_enable", 64'(bus.ch_enable), 64'd1);
    check("rej_depth_stream", 64'(bus.s_din_ready), 64'd1);
    check("rej_depth_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("rej_error_pulse_end", 64'(bus.cfg_error), 64'd0);
    check("rej_stream_after", 64'(bus.s_din_ready), 64'd1);
    send_cfg(24'h111111, 24'h222222, 12'd0, 12'd0, 32'h5);
    check("rej_delay0_error", 64'(bus.cfg_error), 64'd1);
    check("rej_delay0_enable", 64'(bus.ch_enable), 64'd1);
    bus.s_din_valid = 1'b0; bus.ch_dout_valid = 1'b0;
    @(negedge clk);

    // Accept while one sample is inside the chorus; depth==delay is legal
    bus.s_din_valid = 1'b1;
    @(negedge clk);
    bus.s_din_valid = 1'b0;
    send_cfg(24'h100000, 24'h200000, 12'd500, 12'd500, 32'h01234567);
    bus.s_din_valid = 1'b1;
    #1;
    check("drain_cfg_error", 64'(bus.cfg_error), 64'd0);
    check("drain_s_din_ready", 64'(bus.s_din_ready), 64'd0);
    check("drain_ch_din_valid", 64'(bus.ch_din_valid), 64'd0);
    check("drain_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    repeat (5) @(negedge clk);
    check("drain_hold_enable", 64'(bus.ch_enable), 64'd1);
    bus.s_din_valid = 1'b0;
    bus.ch_dout_valid = 1'b1;
    @(negedge clk);
    bus.ch_dout_valid = 1'b0;
    check("drain_last_enable", 64'(bus.ch_enable), 64'd1);
    @(negedge clk);
    check("drain_enable_drop", 64'(bus.ch_enable), 64'd0);
    count_en_low("drain_en_low");
    wait_idle("cfg1");
    check_prog("cfg1", 24'h100000, 24'h200000, 12'd500, 12'd500, 32'h01234567);

    // Same-cycle in/out transfers keep outstanding at one
    bus.s_din_valid = 1'b1;
    @(negedge clk);
    bus.ch_dout_valid = 1'b1;
    @(negedge clk);
    bus.s_din_valid = 1'b0; bus.ch_dout_valid = 1'b0;
    send_cfg(24'h3FFFFF, 24'h000001, 12'd4095, 12'd0, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    check("both_hold_enable", 64'(bus.ch_enable), 64'd1);
    check("both_busy", 64'(bus.busy), 64'd1);
    bus.ch_dout_valid = 1'b1;
    @(negedge clk);
    bus.ch_dout_valid = 1'b0;
    check("both_last_enable", 64'(bus.ch_enable), 64'd1);
    @(negedge clk);
    check("both_enable_drop", 64'(bus.ch_enable), 64'd0);
    count_en_low("both_en_low");
    wait_idle("cfg2");
    check_prog("cfg2", 24'h3FFFFF, 24'h000001, 12'd4095, 12'd0, 32'hFFFFFFFF);

    // Freq channel never ready: timeout into S_ERROR
    freq_rdy_en = 1'b0;
    send_cfg(24'h123456, 24'h654321, 12'd100, 12'd50, 32'hDEADBEEF);
    check("tmo_accept_error", 64'(bus.cfg_error), 64'd0);
    wait_enable("tmo_en_off", 1'b0);
    wait_enable("tmo_en_on", 1'b1);
    check("tmo_freq_valid", 64'(bus.ch_prog_lfo_freq_valid), 64'd1);
    n = 0;
    while (bus.ch_enable && n < TMO + 100) begin n++; @(negedge clk); end
    check("tmo_cycles", 64'(n), 64'(TMO));
    check("tmo_cfg_error", 64'(bus.cfg_error), 64'd1);
    check("tmo_busy", 64'(bus.busy), 64'd1);
    check("tmo_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    check("tmo_freq_valid_off", 64'(bus.ch_prog_lfo_freq_valid), 64'd0);
    check("tmo_s_din_ready", 64'(bus.s_din_ready), 64'd0);
    @(negedge clk);
    check("tmo_error_pulse_end", 64'(bus.cfg_error), 64'd0);
    freq_rdy_en = 1'b1;
    send_cfg(24'h1, 24'h2, 12'd10, 12'd11, 32'h3);
    check("err_reject_error", 64'(bus.cfg_error), 64'd1);
    check("err_reject_enable", 64'(bus.ch_enable), 64'd0);
    check("err_reject_stays", 64'(bus.cfg_ready), 64'd1);
    send_cfg(24'h0AAAAA, 24'h155555, 12'd2048, 12'd1024, 32'h00010000);
    check("err_recover_error", 64'(bus.cfg_error), 64'd0);
    check("err_recover_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    count_en_low("err_en_low");
    wait_idle("cfg3");
    check_prog("cfg3", 24'h0AAAAA, 24'h155555, 12'd2048, 12'd1024, 32'h00010000);

    // Reset asserted mid-S_PROG
    freq_rdy_en = 1'b0;
    send_cfg(24'h777777, 24'h888888, 12'd300, 12'd20, 32'hCAFE);
    wait_enable("prst_en_off", 1'b0);
    wait_enable("prst_en_on", 1'b1);
    repeat (2) @(negedge clk);
    check("prst_freq_valid_pre", 64'(bus.ch_prog_lfo_freq_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("prst_enable", 64'(bus.ch_enable), 64'd0);
    check("prst_valids", 64'({bus.ch_prog_gain_valid, bus.ch_prog_avg_delay_valid,
                               bus.ch_prog_lfo_depth_valid, bus.ch_prog_lfo_freq_valid}), 64'd0);
    check("prst_busy", 64'(bus.busy), 64'd1);
    freq_rdy_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    count_en_low("prst_en_low");
    wait_idle("prst");
    check_prog("prst", 24'h400000, 24'h0, 12'd1024, 12'd256, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
